// File: rtl/hms_pkg.sv
// Shared definitions for the hours/minutes/seconds counter: modes, BCD limits and helpers.
package hms_pkg;

    localparam int unsigned BCD_W = 8;

    localparam logic [BCD_W-1:0] SEC_MAX_BCD = 8'h59;
    localparam logic [BCD_W-1:0] MIN_MAX_BCD = 8'h59;
    localparam logic [BCD_W-1:0] HR_MAX_BCD  = 8'h23;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_CLR_SEC = 2'b11
    } mode_e;

    // Binary 0..99 to two packed BCD digits.
    function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX -> 00; carry flags the wrapping increment.
module bcd_mod_counter
    import hms_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = SEC_MAX_BCD
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] value,
    output logic             carry
);

    logic [3:0]       lo;
    logic [3:0]       hi;
    logic [BCD_W-1:0] next_value;

    assign lo    = value[3:0];
    assign hi    = value[7:4];
    assign carry = inc && !clr && (value == MAX);

    // Out-of-range or non-BCD contents collapse to 00 on the next increment.
    always_comb begin
        next_value = value;
        if (clr) begin
            next_value = '0;
        end else if (inc) begin
            if (value == MAX || lo > 4'd9 || hi > 4'd9 || value > MAX) begin
                next_value = '0;
            end else if (lo == 4'd9) begin
                next_value = {hi + 4'd1, 4'd0};
            end else begin
                next_value = {hi, lo + 4'd1};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/hms_counter.sv
// Time-of-day counter: synchronised 1 Hz tick and increment button drive BCD h:m:s fields.
module hms_counter
    import hms_pkg::*;
#(
    parameter int unsigned HOURS_MAX   = 23,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             run,
    input  logic [1:0]       set_mode,
    input  logic             inc_btn,
    output logic [BCD_W-1:0] sec_bcd,
    output logic [BCD_W-1:0] min_bcd,
    output logic [BCD_W-1:0] hr_bcd,
    output logic             sec_pulse,
    output logic             day_wrap
);

    localparam int unsigned      TOP    = SYNC_STAGES - 1;
    localparam logic [BCD_W-1:0] HR_MAX = (HOURS_MAX == 23) ? HR_MAX_BCD : to_bcd(HOURS_MAX);

    logic [SYNC_STAGES-1:0] tick_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   tick_prev;
    logic                   btn_prev;
    logic                   tick_armed;
    logic                   btn_armed;
    logic                   tick_stb;
    logic                   btn_stb;

    mode_e mode;
    logic  run_mode;
    logic  sec_inc;
    logic  sec_clr;
    logic  min_inc;
    logic  hr_inc;
    logic  sec_carry;
    logic  min_carry;
    logic  hr_carry;

    // fill marks when the last stage holds a post-reset sample, so a level held
    // high through reset release never arms the edge detector.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_sync  <= '0;
            btn_sync   <= '0;
            fill       <= '0;
            tick_prev  <= 1'b0;
            btn_prev   <= 1'b0;
            tick_armed <= 1'b0;
            btn_armed  <= 1'b0;
        end else begin
            tick_sync  <= {tick_sync[SYNC_STAGES-2:0], tick_in};
            btn_sync   <= {btn_sync[SYNC_STAGES-2:0], inc_btn};
            fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
            tick_prev  <= tick_sync[TOP];
            btn_prev   <= btn_sync[TOP];
            tick_armed <= tick_armed | (fill[TOP] & ~tick_sync[TOP]);
            btn_armed  <= btn_armed | (fill[TOP] & ~btn_sync[TOP]);
        end
    end

    assign tick_stb = tick_armed & tick_sync[TOP] & ~tick_prev;
    assign btn_stb  = btn_armed & btn_sync[TOP] & ~btn_prev;

    // Mode arbitration: RUN consumes ticks only, SET modes consume the button only.
    assign mode     = mode_e'(set_mode);
    assign run_mode = (mode == MODE_RUN);
    assign sec_inc  = run_mode & run & tick_stb;
    assign sec_clr  = (mode == MODE_CLR_SEC);
    assign min_inc  = (run_mode & sec_carry) | ((mode == MODE_SET_MIN) & btn_stb);
    assign hr_inc   = (run_mode & min_carry) | ((mode == MODE_SET_HR) & btn_stb);

    bcd_mod_counter #(.MAX(SEC_MAX_BCD)) u_sec (
        .clock (clock),
        .reset (reset),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .value (sec_bcd),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX_BCD)) u_min (
        .clock (clock),
        .reset (reset),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (min_bcd),
        .carry (min_carry)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .clock (clock),
        .reset (reset),
        .inc   (hr_inc),
        .clr   (1'b0),
        .value (hr_bcd),
        .carry (hr_carry)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
        end else begin
            sec_pulse <= sec_inc;
            day_wrap  <= run_mode & hr_carry;
        end
    end

endmodule

// File: tb/tb_hms_counter.sv
// Scoreboard bench for hms_counter against a seconds-of-day reference model.
module tb_hms_counter;
    import hms_pkg::*;

    localparam int HMAX = 23;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick_in = 1'b0;
    logic       run = 1'b0;
    logic [1:0] set_mode = 2'b00;
    logic       inc_btn = 1'b0;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;
    logic       sec_pulse;
    logic       day_wrap;

    hms_counter dut (
        .clock     (clock),
        .reset     (reset),
        .tick_in   (tick_in),
        .run       (run),
        .set_mode  (set_mode),
        .inc_btn   (inc_btn),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hr_bcd    (hr_bcd),
        .sec_pulse (sec_pulse),
        .day_wrap  (day_wrap)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] m;
        logic [7:0] h;
        logic       dw;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ms = 0, mm = 0, mh = 0;
    bit   armed = 0;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_state(input string name);
        check({name, " sec"}, 32'(sec_bcd), 32'(bcd(ms)));
        check({name, " min"}, 32'(min_bcd), 32'(bcd(mm)));
        check({name, " hr"},  32'(hr_bcd),  32'(bcd(mh)));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference: advance the time of day by one second, wrapping at midnight.
    task automatic model_advance();
        int   t;
        exp_t e;
        t  = ((mh * 60 + mm) * 60 + ms + 1) % ((HMAX + 1) * 3600);
        mh = t / 3600;
        mm = (t / 60) % 60;
        ms = t % 60;
        e.s = bcd(ms);
        e.m = bcd(mm);
        e.h = bcd(mh);
        e.dw = (t == 0);
        exp_q.push_back(e);
    endtask

    task automatic model_press();
        if (set_mode == 2'b01) mh = (mh + 1) % (HMAX + 1);
        else if (set_mode == 2'b10) mm = (mm + 1) % 60;
    endtask

    task automatic tick(input int hi_len, input int lo_len);
        bit adv;
        adv = armed && (set_mode == 2'b00) && run;
        if (adv) model_advance();
        tick_in = 1'b1;
        cycles(2);
        check("pulse before edge 3", 32'(sec_pulse), 0);
        cycles(1);
        check("pulse at edge 3", 32'(sec_pulse), 32'(adv));
        cycles(hi_len);
        tick_in = 1'b0;
        cycles(lo_len);
        armed = 1;
    endtask

    task automatic press();
        model_press();
        inc_btn = 1'b1;
        cycles(4);
        inc_btn = 1'b0;
        cycles(4);
    endtask

    task automatic both();
        if (armed && set_mode == 2'b00 && run) model_advance();
        model_press();
        tick_in = 1'b1;
        inc_btn = 1'b1;
        cycles(5);
        tick_in = 1'b0;
        inc_btn = 1'b0;
        cycles(5);
    endtask

    task automatic set_md(input logic [1:0] md);
        set_mode = md;
        cycles(1);
        if (md == 2'b11) ms = 0;
        cycles(1);
    endtask

    task automatic check_zero(input string name);
        check({name, " sec"}, 32'(sec_bcd), 0);
        check({name, " min"}, 32'(min_bcd), 0);
        check({name, " hr"}, 32'(hr_bcd), 0);
        check({name, " sec_pulse"}, 32'(sec_pulse), 0);
        check({name, " day_wrap"}, 32'(day_wrap), 0);
    endtask

    // Monitor: every seconds strobe retires one expected record.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            if (sec_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected sec_pulse", 32'(sec_pulse), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse sec", 32'(sec_bcd), 32'(e.s));
                    check("pulse min", 32'(min_bcd), 32'(e.m));
                    check("pulse hr", 32'(hr_bcd), 32'(e.h));
                    check("pulse day_wrap", 32'(day_wrap), 32'(e.dw));
                end
            end else begin
                check("day_wrap without pulse", 32'(day_wrap), 0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int md;
        cycles(3);
        check_zero("in reset");
        reset = 1'b1;
        cycles(5);
        armed = 1;
        check_state("after reset");

        // Basic counting.
        set_md(2'b00);
        run = 1'b1;
        repeat (5) tick($urandom_range(1, 6), $urandom_range(4, 8));
        check_state("basic count");

        // Minute and hour carry from 00:59:58.
        set_md(2'b10);
        repeat (59) press();
        set_md(2'b11);
        set_md(2'b00);
        repeat (58) tick(1, 4);
        check_state("preset 00:59:58");
        tick(1, 4);
        tick(2, 5);
        check_state("carry 01:00:00");

        // Day wrap from 23:59:59.
        set_md(2'b01);
        repeat (22) press();
        set_md(2'b10);
        repeat (59) press();
        set_md(2'b11);
        set_md(2'b00);
        repeat (59) tick(1, 4);
        check_state("preset 23:59:59");
        tick(1, 4);
        check_state("day wrap");

        // Set-mode wrapping.
        set_md(2'b01);
        repeat (25) press();
        check_state("25 hour presses");
        set_md(2'b10);
        repeat (61) press();
        check_state("61 minute presses");

        // Suppression in run=0, SET_MIN, CLR_SEC, then resume.
        set_md(2'b00);
        tick(1, 4);
        run = 1'b0;
        repeat (3) tick(1, 4);
        check_state("run=0 frozen");
        run = 1'b1;
        set_md(2'b10);
        repeat (2) tick(1, 4);
        check_state("set_min frozen");
        set_md(2'b11);
        check_state("clr_sec");
        set_md(2'b00);
        cycles(5);
        check_state("resume before tick");
        tick(1, 4);
        check_state("resume after tick");

        // Randomised mix including simultaneous tick and button.
        repeat (60) begin
            md = $urandom_range(0, 3);
            set_md(2'(md));
            run = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: tick($urandom_range(1, 5), $urandom_range(4, 7));
                1: press();
                default: both();
            endcase
            check_state("random");
        end

        // Reset while a tick sits in the synchroniser.
        set_md(2'b00);
        run = 1'b1;
        tick_in = 1'b1;
        cycles(1);
        reset = 1'b0;
        #2;
        check_zero("mid reset");
        ms = 0; mm = 0; mh = 0; armed = 0;
        tick_in = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(5);
        armed = 1;
        check_state("after mid reset");
        tick(1, 4);
        check_state("count after mid reset");

        // tick_in held high through reset release.
        reset = 1'b0;
        ms = 0; mm = 0; mh = 0; armed = 0;
        tick_in = 1'b1;
        cycles(2);
        reset = 1'b1;
        cycles(10);
        check_state("high at release");
        tick_in = 1'b0;
        cycles(5);
        check_state("after low");
        armed = 1;
        tick(1, 4);
        check_state("first valid tick");

        cycles(5);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hms_counter.md
HMS_COUNTER -- requirements
Module: hms_counter

Interface
REQ-001 Parameter HOURS_MAX, default 23: highest hour value before wrap to 00.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth for tick_in and inc_btn; legal range 2..3.
REQ-003 clock  input  1  system clock, 1 kHz nominal; every register in the block is clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick_in  input  1  divided 1 Hz square wave from the upstream divider, asynchronous to clock.
REQ-006 run  input  1  count enable; 1 = advance on each second tick.
REQ-007 set_mode  input  2  00 RUN, 01 SET_HR, 10 SET_MIN, 11 CLR_SEC.
REQ-008 inc_btn  input  1  increment button level, asynchronous, already debounced.
REQ-009 sec_bcd  output  8  seconds, two BCD digits, 00..59.
REQ-010 min_bcd  output  8  minutes, two BCD digits, 00..59.
REQ-011 hr_bcd  output  8  hours, two BCD digits, 00..HOURS_MAX.
REQ-012 sec_pulse  output  1  one-cycle strobe on each seconds advance.
REQ-013 day_wrap  output  1  one-cycle strobe on the HOURS_MAX:59:59 -> 00:00:00 transition.

Function
REQ-014 tick_in and inc_btn shall each pass through a SYNC_STAGES flip-flop synchroniser, then a rising-edge detector producing a one-cycle strobe.
REQ-015 Latency (SYNC_STAGES=2): counters and sec_pulse shall update at the 3rd rising clock edge, counting the first edge that samples tick_in=1 as edge 1.
REQ-016 The edge detectors shall produce no strobe until their synchronised input has been sampled low at least once after reset release.
REQ-017 In RUN with run=1, each tick strobe shall increment seconds; low digit wraps 9->0 with carry to the high digit; high digit wraps 5->0.
REQ-018 Seconds 59 plus tick shall give 00 and increment minutes in the same cycle.
REQ-019 Minutes 59 plus carry shall give 00 and increment hours in the same cycle.
REQ-020 Hours HOURS_MAX plus carry shall give 00 and assert day_wrap for exactly that cycle.
REQ-021 In RUN with run=0, ticks shall be discarded, not queued.
REQ-022 In any mode other than RUN, ticks shall be discarded, sec_pulse shall stay 0 and seconds shall not advance.
REQ-023 In SET_HR, each inc_btn strobe shall increment hours by 1 and wrap HOURS_MAX->00, with no day_wrap and no effect on the other fields.
REQ-024 In SET_MIN, each inc_btn strobe shall increment minutes by 1 and wrap 59->00, with no carry into hours.
REQ-025 In CLR_SEC, seconds shall be forced to 00 every cycle, and inc_btn shall be ignored.
REQ-026 In RUN, inc_btn shall be ignored.
REQ-027 A set_mode change shall take effect on the next clock edge.
REQ-028 A tick and an inc_btn strobe arriving in the same cycle shall be resolved by mode: RUN uses only the tick, SET modes use only inc_btn.
REQ-029 sec_pulse and day_wrap shall be registered outputs.
REQ-030 BCD digits shall never hold the values A..F.
REQ-031 Non-BCD internal states shall recover to 00 on the next update.

Reset
REQ-032 While reset=0, every register shall clear immediately: sec_bcd, min_bcd and hr_bcd = 8'h00, sec_pulse = 0, day_wrap = 0, and the synchroniser and edge registers = 0.
REQ-033 Reset asserted mid-count shall discard any in-flight tick.
REQ-034 After reset release, counting shall resume only on a tick that satisfies REQ-016.

Structure
REQ-035 Shared package hms_pkg shall hold the mode encodings, the BCD limit constants 8'h59 and 8'h23, and the BCD width of 8.
REQ-036 One sub-module, bcd_mod_counter, shall implement a two-digit BCD counter with parameter MAX, inputs inc and clr, outputs value and carry.
REQ-037 bcd_mod_counter shall be instantiated three times: seconds, minutes and hours.
REQ-038 The synchronisers and edge detectors shall be written inline in hms_counter.

Verification
REQ-039 Reset and basic count: reset low then released, run=1, RUN mode, tick_in toggling every 500 cycles -> sec_bcd 00,01,02..., with sec_pulse high for one cycle per tick at edge 3 after each rise.
REQ-040 Minute and hour carry: preset 00:59:58 via SET modes, then run -> 00:59:59, then 01:00:00, with min_bcd and hr_bcd changing in the same cycle.
REQ-041 Day wrap: preset 23:59:59, then one tick -> 00:00:00 and day_wrap=1 for exactly one cycle.
REQ-042 Set modes: SET_HR with 25 inc_btn presses from 00 -> hr_bcd=01 and day_wrap never asserted; SET_MIN with 61 presses -> min_bcd=01 and hr_bcd unchanged.
REQ-043 Suppression: ticks during run=0 or SET_MIN -> sec_bcd frozen; CLR_SEC -> sec_bcd=00; returning to RUN -> counting resumes from 00 on the next tick only.
REQ-044 Reset mid-operation and high-at-release: reset pulse while a tick is in the synchroniser -> all outputs 00; tick_in held high through reset release -> no advance until tick_in goes low and then high again.
